calc_entry_ctrl: RTL and testbench
==================================

Name: calc_entry_ctrl

Overview:
- Sequencing controller between the keyboard key-code decoder and the calculator ALU.
- Consumes one 4-bit key code per valid pulse and accumulates decimal digits into operand A and operand B. It also captures the operator.
- On ENTER, issues a req/ack transaction to the ALU, captures the result and holds it for display.

Parameters:
- DATA_W, 8: operand/result width in bits; unsigned.
- MAX_DIGITS, 3: maximum decimal digits accepted per operand.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  single-cycle strobe; key_code is valid this cycle.
- key_code  in  4  0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 MOD, 14 ENTER, 15 CLEAR.
- operand_a  out  DATA_W  registered operand A to ALU.
- operand_b  out  DATA_W  registered operand B to ALU.
- op_sel  out  2  0 ADD, 1 SUB, 2 MUL, 3 MOD.
- alu_req  out  1  level request to ALU.
- alu_ack  in  1  ALU result valid; single cycle.
- alu_result  in  DATA_W  ALU result, sampled when alu_ack=1.
- display_val  out  DATA_W  value to show on the display.
- busy  out  1  high in WAIT_ALU.

Behaviour:
- Reset: all outputs 0; state ENTER_A; digit counters 0.
- Keys are sampled only when key_valid=1. All outputs are registered, so the effect appears 1 cycle after the key.
- Digit accumulation: acc_next = acc*10 + digit, saturating at 2^DATA_W-1.
  - A digit is accepted only if digit_cnt < MAX_DIGITS; otherwise it is ignored.
  - The counter increments on each accepted digit.
- ENTER_A:
  - Digit: accumulate into operand_a.
  - Operator: set op_sel, go to ENTER_B. B and its counter are cleared.
  - ENTER: result := operand_a, go to SHOW. No ALU transaction.
  - CLEAR: zero A, B, op_sel and counters; stay in ENTER_A.
- ENTER_B:
  - Digit: accumulate into operand_b.
  - Operator: replaces op_sel if B has 0 digits; otherwise ignored.
  - ENTER with 0 B digits: ignored.
  - ENTER with at least 1 B digit: go to WAIT_ALU; alu_req=1 from the next cycle.
  - CLEAR: as in ENTER_A.
- WAIT_ALU:
  - alu_req held high; operand_a, operand_b and op_sel held stable.
  - All keys ignored, including CLEAR.
  - When alu_ack=1: capture alu_result into the result register, go to SHOW; alu_req=0 on the next cycle.
  - An alu_ack outside WAIT_ALU is ignored.
- SHOW:
  - Digit: clear A, B and counters; that digit becomes the first digit of A; go to ENTER_A.
  - CLEAR: go to ENTER_A cleared.
  - ENTER: ignored.
  - Operator: per the optional feature.
- display_val by state:
  - ENTER_A: operand_a.
  - ENTER_B: operand_b if B has digits, else operand_a.
  - WAIT_ALU: operand_b.
  - SHOW: result.
- busy = 1 exactly while in WAIT_ALU.
- rst asserted in any state, including mid-transaction, returns to reset values next cycle; alu_req drops immediately.

Optional Feature:
- Macro: CALC_CHAIN_EN.
- Defined: an operator in SHOW loads operand_a := result with digit count MAX_DIGITS (blocks appending), sets op_sel, clears B, and goes to ENTER_B.
- Undefined: an operator in SHOW is ignored.

Decomposition:
- Package calc_pkg holds:
  - key code localparams (KEY_ADD=10 … KEY_CLEAR=15);
  - op_sel enum typedef;
  - FSM state enum typedef (ENTER_A, ENTER_B, WAIT_ALU, SHOW).
- One sub-module, digit_accum: the saturating ×10+digit accumulator with digit counter, clear and load inputs. Instantiated twice, for A and B.

Test Plan:
- Keys 1,2,ADD,3,ENTER; ack after 4 cycles with result 15 → operand_a=12, operand_b=3, op_sel=0; alu_req high 4 cycles then low; display_val=15; busy=0.
- Keys 9,9,9,9 → operand_a=255, saturated; 4th digit ignored; display_val=255.
- Keys 5,ADD,SUB,MUL,2,ENTER → op_sel=2, operand_b=2, alu_req asserted.
- Keys 7,ENTER → display_val=7, alu_req never asserts.
- During WAIT_ALU, press CLEAR and digit 4 → no change; then assert rst → alu_req=0 and all outputs 0 next cycle.
- With CALC_CHAIN_EN: after result 15 press ADD,1,ENTER → operand_a=15, operand_b=1, alu_req asserted. Without the macro: ADD has no effect and display_val stays 15.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, operator and FSM state types for the calculator entry controller
package calc_pkg;

  localparam logic [3:0] KEY_ADD   = 4'd10;
  localparam logic [3:0] KEY_SUB   = 4'd11;
  localparam logic [3:0] KEY_MUL   = 4'd12;
  localparam logic [3:0] KEY_MOD   = 4'd13;
  localparam logic [3:0] KEY_ENTER = 4'd14;
  localparam logic [3:0] KEY_CLEAR = 4'd15;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_MOD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ENTER_A,
    ENTER_B,
    WAIT_ALU,
    SHOW
  } state_e;

  function automatic op_e key_to_op(input logic [3:0] k);
    case (k)
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      KEY_MOD: return OP_MOD;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/digit_accum.sv
// rtl/digit_accum.sv - saturating decimal digit accumulator with digit counter, clear and load
module digit_accum #(
  parameter int DATA_W     = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              digit_en,
  input  logic [3:0]        digit,
  output logic [DATA_W-1:0] value,
  output logic              empty
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int WW = DATA_W + 4;

  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] base_val;
  logic [CW-1:0]     base_cnt;
  logic [WW-1:0]     wide;
  logic [DATA_W-1:0] sat_val;

  // clear together with a digit makes that digit the first one of a fresh operand
  always_comb begin
    base_val = clear ? '0 : value;
    base_cnt = clear ? '0 : cnt;
    wide     = WW'(base_val) * WW'(10) + WW'(digit);
    sat_val  = (wide > WW'({DATA_W{1'b1}})) ? '1 : wide[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      cnt   <= '0;
    end else if (digit_en && (base_cnt < CW'(MAX_DIGITS))) begin
      value <= sat_val;
      cnt   <= base_cnt + CW'(1);
    end else if (load) begin
      value <= load_val;
      cnt   <= CW'(MAX_DIGITS);
    end else if (clear) begin
      value <= '0;
      cnt   <= '0;
    end
  end

  assign empty = (cnt == '0);

endmodule

// File: rtl/calc_entry_ctrl.sv
// rtl/calc_entry_ctrl.sv - calculator key entry sequencer with ALU req/ack handshake; CALC_CHAIN_EN enables result chaining
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic [1:0]        op_sel,
  output logic              alu_req,
  input  logic              alu_ack,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] display_val,
  output logic              busy
);

  state_e            state, state_next;
  op_e               op_q, op_next;
  logic [DATA_W-1:0] result_q, result_next;
  logic              a_clear, a_load, a_digit, b_clear, b_digit;
  logic              a_empty_unused, b_empty;
  logic              is_digit, is_op;

  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code >= KEY_ADD) && (key_code <= KEY_MOD);

  digit_accum #(.DATA_W(DATA_W), .MAX_DIGITS(MAX_DIGITS)) u_acc_a (
    .clk(clk), .rst(rst), .clear(a_clear), .load(a_load), .load_val(result_q),
    .digit_en(a_digit), .digit(key_code), .value(operand_a), .empty(a_empty_unused)
  );

  digit_accum #(.DATA_W(DATA_W), .MAX_DIGITS(MAX_DIGITS)) u_acc_b (
    .clk(clk), .rst(rst), .clear(b_clear), .load(1'b0), .load_val('0),
    .digit_en(b_digit), .digit(key_code), .value(operand_b), .empty(b_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ENTER_A;
      op_q     <= OP_ADD;
      result_q <= '0;
    end else begin
      state    <= state_next;
      op_q     <= op_next;
      result_q <= result_next;
    end
  end

  always_comb begin
    state_next  = state;
    op_next     = op_q;
    result_next = result_q;
    a_clear     = 1'b0;
    a_load      = 1'b0;
    a_digit     = 1'b0;
    b_clear     = 1'b0;
    b_digit     = 1'b0;
    case (state)
      ENTER_A: if (key_valid) begin
        if (is_digit) a_digit = 1'b1;
        else if (is_op) begin
          op_next    = key_to_op(key_code);
          b_clear    = 1'b1;
          state_next = ENTER_B;
        end else if (key_code == KEY_ENTER) begin
          result_next = operand_a;
          state_next  = SHOW;
        end else begin
          a_clear = 1'b1;
          b_clear = 1'b1;
          op_next = OP_ADD;
        end
      end
      ENTER_B: if (key_valid) begin
        if (is_digit) b_digit = 1'b1;
        else if (is_op) begin
          if (b_empty) op_next = key_to_op(key_code);
        end else if (key_code == KEY_ENTER) begin
          if (!b_empty) state_next = WAIT_ALU;
        end else begin
          a_clear    = 1'b1;
          b_clear    = 1'b1;
          op_next    = OP_ADD;
          state_next = ENTER_A;
        end
      end
      // keys are deliberately ignored here so the operands stay stable under req
      WAIT_ALU: if (alu_ack) begin
        result_next = alu_result;
        state_next  = SHOW;
      end
      SHOW: if (key_valid) begin
        if (is_digit) begin
          a_clear    = 1'b1;
          a_digit    = 1'b1;
          b_clear    = 1'b1;
          state_next = ENTER_A;
        end else if (key_code == KEY_CLEAR) begin
          a_clear    = 1'b1;
          b_clear    = 1'b1;
          op_next    = OP_ADD;
          state_next = ENTER_A;
        end else if (is_op) begin
`ifdef CALC_CHAIN_EN
          a_load     = 1'b1;
          b_clear    = 1'b1;
          op_next    = key_to_op(key_code);
          state_next = ENTER_B;
`else
          state_next = SHOW;
`endif
        end
      end
      default: state_next = ENTER_A;
    endcase
  end

  always_comb begin
    display_val = operand_a;
    case (state)
      ENTER_A:  display_val = operand_a;
      ENTER_B:  display_val = b_empty ? operand_a : operand_b;
      WAIT_ALU: display_val = operand_b;
      SHOW:     display_val = result_q;
      default:  display_val = operand_a;
    endcase
  end

  assign op_sel  = op_q;
  assign alu_req = (state == WAIT_ALU);
  assign busy    = (state == WAIT_ALU);

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb/tb_calc_entry_ctrl.sv - scoreboard bench for calc_entry_ctrl; honours CALC_CHAIN_EN
module tb_calc_entry_ctrl;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst, key_valid, alu_ack;
  logic [3:0] key_code;
  logic [7:0] operand_a, operand_b, alu_result, display_val;
  logic [1:0] op_sel;
  logic       alu_req, busy;

  calc_entry_ctrl #(.DATA_W(8), .MAX_DIGITS(3)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .operand_a(operand_a), .operand_b(operand_b), .op_sel(op_sel),
    .alu_req(alu_req), .alu_ack(alu_ack), .alu_result(alu_result),
    .display_val(display_val), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] a, b;
    logic [1:0] op;
    logic       req;
    logic [7:0] disp;
    logic       bsy;
  } snap_t;

  typedef struct {
    logic [7:0] a, b;
    logic [1:0] op;
    int         len;
  } txn_t;

  typedef struct {
    int         delay;
    logic [7:0] res;
  } resp_t;

  snap_t snap_q[$];
  txn_t  txn_q[$];
  resp_t resp_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic snap(input string n, input int a, input int b, input int op,
                      input int req, input int disp, input int bsy);
    snap_t s;
    s.name = n; s.a = 8'(a); s.b = 8'(b); s.op = 2'(op);
    s.req = 1'(req); s.disp = 8'(disp); s.bsy = 1'(bsy);
    snap_q.push_back(s);
  endtask

  task automatic txn(input int a, input int b, input int op, input int len);
    txn_t t;
    t.a = 8'(a); t.b = 8'(b); t.op = 2'(op); t.len = len;
    txn_q.push_back(t);
  endtask

  task automatic resp(input int delay, input int res);
    resp_t r;
    r.delay = delay; r.res = 8'(res);
    resp_q.push_back(r);
  endtask

  task automatic press(input logic [3:0] k);
    @(posedge clk); #1;
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // snapshot monitor
  initial begin
    snap_t s;
    forever begin
      @(negedge clk);
      while (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        chk({s.name, ".operand_a"},   operand_a,   s.a);
        chk({s.name, ".operand_b"},   operand_b,   s.b);
        chk({s.name, ".op_sel"},      op_sel,      s.op);
        chk({s.name, ".alu_req"},     alu_req,     s.req);
        chk({s.name, ".display_val"}, display_val, s.disp);
        chk({s.name, ".busy"},        busy,        s.bsy);
      end
    end
  end

  // ALU transaction monitor: operands at req rise, req length at fall
  initial begin
    txn_t t;
    logic prev = 1'b0;
    int   run = 0;
    int   exp_len = 0;
    forever begin
      @(negedge clk);
      if (alu_req && !prev) begin
        run = 1;
        if (txn_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_req: got alu_req=1 expected no request");
          exp_len = 0;
        end else begin
          t = txn_q.pop_front();
          exp_len = t.len;
          chk("txn.operand_a", operand_a, t.a);
          chk("txn.operand_b", operand_b, t.b);
          chk("txn.op_sel",    op_sel,    t.op);
          chk("txn.busy",      busy,      1);
        end
      end else if (alu_req) begin
        run++;
      end else if (prev && exp_len != 0) begin
        chk("txn.req_cycles", run, exp_len);
      end
      prev = alu_req;
    end
  end

  // ALU model: acks after the queued number of request cycles; delay 0 never acks
  initial begin
    resp_t r;
    logic  have = 1'b0;
    int    cnt = 0;
    alu_ack = 1'b0;
    alu_result = 8'd0;
    forever begin
      @(negedge clk);
      if (alu_req) begin
        if (!have) begin
          have = 1'b1;
          cnt = 0;
          if (resp_q.size() > 0) r = resp_q.pop_front();
          else r.delay = 0;
        end
        cnt++;
        if (r.delay != 0 && cnt == r.delay) begin
          alu_ack = 1'b1;
          alu_result = r.res;
          @(posedge clk); #1;
          alu_ack = 1'b0;
          alu_result = 8'd0;
        end
      end else begin
        have = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    key_valid = 1'b0;
    key_code = 4'd0;
    idle(3);
    rst = 1'b0;
    snap("reset", 0, 0, 0, 0, 0, 0);

    // 12 + 3, ack after 4 request cycles
    press(4'd1); press(4'd2); press(KEY_ADD);
    snap("a_op", 12, 0, 0, 0, 12, 0);
    press(4'd3);
    txn(12, 3, 0, 4); resp(4, 15);
    press(KEY_ENTER);
    idle(8);
    snap("add_result", 12, 3, 0, 0, 15, 0);

    // digit from SHOW starts new A; saturation at 255
    press(4'd9); press(4'd9);
    snap("show_digit", 99, 0, 0, 0, 99, 0);
    press(4'd9); press(4'd9);
    snap("saturate", 255, 0, 0, 0, 255, 0);
    press(KEY_CLEAR); press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    snap("max_digits", 123, 0, 0, 0, 123, 0);
    press(KEY_CLEAR);
    snap("clear", 0, 0, 0, 0, 0, 0);

    // operator replacement, ENTER without B, operator after B digit
    press(4'd5); press(KEY_ADD); press(KEY_SUB); press(KEY_MUL);
    snap("op_replace", 5, 0, 2, 0, 5, 0);
    press(KEY_ENTER);
    snap("enter_no_b", 5, 0, 2, 0, 5, 0);
    press(4'd2); press(KEY_SUB);
    snap("op_after_b", 5, 2, 2, 0, 2, 0);
    txn(5, 2, 2, 4); resp(4, 10);
    press(KEY_ENTER);
    idle(8);
    snap("mul_result", 5, 2, 2, 0, 10, 0);

    // ENTER straight from A: no ALU transaction
    press(KEY_CLEAR); press(4'd7); press(KEY_ENTER);
    idle(6);
    snap("enter_a", 7, 0, 0, 0, 7, 0);
    press(KEY_ENTER);
    snap("show_enter", 7, 0, 0, 0, 7, 0);

    // keys ignored in WAIT_ALU, then reset mid-transaction
    press(KEY_CLEAR); press(4'd1); press(KEY_ADD); press(4'd2);
    txn(1, 2, 0, 0); resp(0, 0);
    press(KEY_ENTER);
    press(KEY_CLEAR); press(4'd4);
    snap("wait_hold", 1, 2, 0, 1, 2, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    snap("mid_reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // operator while showing a result
    press(4'd1); press(4'd2); press(KEY_ADD); press(4'd3);
    txn(12, 3, 0, 4); resp(4, 15);
    press(KEY_ENTER);
    idle(8);
    snap("result2", 12, 3, 0, 0, 15, 0);
`ifdef CALC_CHAIN_EN
    txn(15, 1, 0, 4); resp(4, 16);
    press(KEY_ADD);
    snap("chain_op", 15, 0, 0, 0, 15, 0);
    press(4'd1); press(KEY_ENTER);
    idle(8);
    snap("chain_result", 15, 1, 0, 0, 16, 0);
`else
    press(KEY_SUB);
    snap("show_op_ignored", 12, 3, 0, 0, 15, 0);
    press(KEY_ADD);
    snap("show_add_ignored", 12, 3, 0, 0, 15, 0);
`endif

    idle(2);
    for (int i = 0; i < 50 && (snap_q.size() > 0 || txn_q.size() > 0); i++) @(posedge clk);
    if (snap_q.size() > 0 || txn_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", snap_q.size() + txn_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
